hba_quad: RTL and testbench
===========================

# hba_quad

Dual-channel quadrature encoder peripheral for HBA bus slot 3, feeding the slave OR-combiner and interrupt vector alongside basicio and sonar. It synchronises two A/B encoder pin pairs and decodes them ×4 into signed 16-bit wrapping position counts. It exposes the counts to the bus master through an atomic snapshot and raises an interrupt when either wheel has moved since the last snapshot.

## Interface
- DBUS_WIDTH, 8, bus data width; only 8 is supported.
- PERIPH_ADDR_WIDTH, 4, slot-select field width.
- REG_ADDR_WIDTH, 8, register-select field width.
- PERIPH_ADDR, 3, slot this instance answers.
- hba_clk  in  1  single clock for all logic.
- hba_reset  in  1  asynchronous, active-high reset.
- hba_rnw  in  1  1 = read, 0 = write.
- hba_select  in  1  transfer in progress.
- hba_abus  in  PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH  address; `[11:8]` = slot, `[7:0]` = register.
- hba_dbus  in  8  write data.
- hba_dbus_slave  out  8  read data; 0 except during this slave's ack cycle.
- hba_xferack_slave  out  1  one-cycle transfer acknowledge; 0 when inactive.
- slave_interrupt  out  1  level interrupt to serial_fpga.
- quad_enc_a  in  2  encoder A pins; bit 0 = left, bit 1 = right.
- quad_enc_b  in  2  encoder B pins; same indexing.

## Operation
- **Bus FSM states:** IDLE, ACK, WAIT.
  - IDLE → ACK on a clock edge where `hba_select=1` and `hba_abus[11:8]==PERIPH_ADDR`.
  - On that same edge: latch read data into `rdata`, perform write or side effects.
  - ACK: `xferack=1`, `dbus_slave=rdata`, lasting exactly one cycle.
  - ACK → WAIT unconditionally.
  - WAIT → IDLE when `hba_select=0`. A held select never causes a second ack or a repeated side effect.
- **Register map** (unlisted addresses read 0; writes to them are ignored):
  - 0 CTRL (rw):
    - bit0 EN: counting enable.
    - bit1 INTR_EN.
    - bit2 CLR: write-1 zeroes both counts and both error flags; not stored, reads 0.
    - bits 7:3 read 0.
  - 1 LEFT_LO (r): returns live `left[7:0]`. Side effect: copies `left[15:0]` and `right[15:0]` into shadow registers and clears both moved flags.
  - 2 LEFT_HI (r): `shadow_left[15:8]`.
  - 3 RIGHT_LO (r): `shadow_right[7:0]`.
  - 4 RIGHT_HI (r): `shadow_right[15:8]`.
  - 5 STATUS (r):
    - bit0 ERR_L, bit1 ERR_R.
    - bit2 MOVED_L, bit3 MOVED_R.
    - A write of any value to 5 clears ERR_L and ERR_R.
- **Decoder (per channel):**
  - Synchronise A and B through 2 flops each.
  - `prev` register holds the last synchronised AB pair.
  - Increment sequence, as AB: 00→10→11→01→00. The reverse order decrements.
  - Both bits changing in one step: count unchanged, ERR sticky-set.
  - No change: nothing happens.
  - `prev` updates every cycle regardless of EN, so re-enabling never produces a spurious step.
- **Counts:** 16-bit two's complement with wrap.
  - 0xFFFF + 1 = 0x0000.
  - 0x0000 − 1 = 0xFFFF.
  - No saturation.
- **Moved flags:** MOVED_x sets on any counted step of channel x.
- **Interrupt:** `slave_interrupt = INTR_EN & (MOVED_L | MOVED_R)`, registered.

## Timing
- **Reset values:** all outputs 0. CTRL, counts, shadows, flags and `prev` = 0. Sync flops = 0. FSM = IDLE.
- **Reset mid-transfer:** asynchronous; ack drops immediately and no side effect is completed.
- **Pin-to-count latency:** a pin change is reflected in the count after the 3rd rising edge following it. The edges are sync1, sync2, then count/`prev`.
- **Bus latency:** select is sampled at edge k; ack is high from edge k to k+1. The earliest next ack is 2 cycles after select drops.
- **CLR vs. step on the same edge:** CLR wins; count = 0.
- **Snapshot vs. step on the same edge:** the shadow takes the pre-step value and MOVED ends at 1, so no event is lost.
- **EN=0:** counts and MOVED hold; ERR still sets on illegal steps.
- **Interrupt latency:** the interrupt follows the flag change by 1 cycle.

## Test plan
- **Reset:** assert `hba_reset` mid-ack → `xferack`, `dbus_slave`, `slave_interrupt` = 0 at once. Read all registers after release → all 0.
- **Forward count:** EN=1; drive left AB 00→10→11→01→00 ×4 (16 steps), ≥3 cycles apart → read 1,2 returns 0x10, 0x00. MOVED_L was 1 before the read and is 0 after.
- **Wrap and reverse:** from 0, one reverse step on right → read 1,3,4 gives right = 0xFFFF. Then 2 forward steps → 0x0001.
- **Illegal step:** left AB 00→11 → count unchanged, STATUS bit0 = 1. Write reg 5 → STATUS bit0 = 0.
- **Interrupt and snapshot atomicity:** CTRL = 0x03. A right step raises the interrupt 4 cycles after the pin change. Read reg 1 with a simultaneous left step → shadow holds the old value, interrupt stays high, next snapshot shows +1.
- **Bus protocol:**
  - Hold select for 5 cycles on a CTRL write of 0x07 → exactly one ack; CTRL reads 0x03; counts are 0.
  - Access slot 2 → no ack, `dbus_slave` = 0.

Source files
------------

// File: rtl/hba_quad.sv
// Dual-channel x4 quadrature decoder on HBA slot 3: synchronised A/B pins feed
// signed 16-bit wrapping counts, read through an atomic snapshot, with a moved interrupt.
module hba_quad #(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int PERIPH_ADDR       = 3
) (
    input  logic                                      hba_clk,
    input  logic                                      hba_reset,
    input  logic                                      hba_rnw,
    input  logic                                      hba_select,
    input  logic [PERIPH_ADDR_WIDTH+REG_ADDR_WIDTH-1:0] hba_abus,
    input  logic [DBUS_WIDTH-1:0]                     hba_dbus,
    output logic [DBUS_WIDTH-1:0]                     hba_dbus_slave,
    output logic                                      hba_xferack_slave,
    output logic                                      slave_interrupt,
    input  logic [1:0]                                quad_enc_a,
    input  logic [1:0]                                quad_enc_b
);

    localparam int ABUS_W = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH;
    localparam logic [PERIPH_ADDR_WIDTH-1:0] SLOT = PERIPH_ADDR_WIDTH'(PERIPH_ADDR);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_CTRL     = 'd0;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_LEFT_LO  = 'd1;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_LEFT_HI  = 'd2;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_RIGHT_LO = 'd3;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_RIGHT_HI = 'd4;
    localparam logic [REG_ADDR_WIDTH-1:0] REG_STATUS   = 'd5;

    typedef enum logic [1:0] {ST_IDLE, ST_ACK, ST_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [DBUS_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    en_q, en_d;
    logic                    intr_en_q, intr_en_d;
    logic [1:0]              a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic [1:0]              b_s1_q, b_s1_d, b_s2_q, b_s2_d;
    logic [1:0]              prev_a_q, prev_a_d, prev_b_q, prev_b_d;
    logic [1:0][15:0]        cnt_q, cnt_d;
    logic [1:0][15:0]        shadow_q, shadow_d;
    logic [1:0]              err_q, err_d;
    logic [1:0]              moved_q, moved_d;
    logic                    irq_q, irq_d;

    logic [1:0]              step_inc, step_dec, step_bad;
    logic                    sel_hit, accept, snap, ctrl_wr, clr, status_wr;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [DBUS_WIDTH-1:0]   rd_mux;
    logic                    unused_dbus;

    assign unused_dbus = ^hba_dbus[DBUS_WIDTH-1:3];
    assign reg_addr    = hba_abus[REG_ADDR_WIDTH-1:0];
    assign sel_hit     = hba_select && (hba_abus[ABUS_W-1:REG_ADDR_WIDTH] == SLOT);

    // Transition table on {prev AB, current AB}; forward order is 00->10->11->01->00.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            step_inc[ch] = 1'b0;
            step_dec[ch] = 1'b0;
            step_bad[ch] = 1'b0;
            case ({prev_a_q[ch], prev_b_q[ch], a_s2_q[ch], b_s2_q[ch]})
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: step_inc[ch] = 1'b1;
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_dec[ch] = 1'b1;
                4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: step_bad[ch] = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_CTRL:     rd_mux = {6'b0, intr_en_q, en_q};
            REG_LEFT_LO:  rd_mux = cnt_q[0][7:0];
            REG_LEFT_HI:  rd_mux = shadow_q[0][15:8];
            REG_RIGHT_LO: rd_mux = shadow_q[1][7:0];
            REG_RIGHT_HI: rd_mux = shadow_q[1][15:8];
            REG_STATUS:   rd_mux = {4'b0, moved_q[1], moved_q[0], err_q[1], err_q[0]};
            default:      rd_mux = '0;
        endcase
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_hit) begin
                    state_d = ST_ACK;
                    accept  = 1'b1;
                    rdata_d = hba_rnw ? rd_mux : '0;
                end
            end
            ST_ACK:  state_d = ST_WAIT;
            ST_WAIT: if (!hba_select) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign snap      = accept &&  hba_rnw && (reg_addr == REG_LEFT_LO);
    assign ctrl_wr   = accept && !hba_rnw && (reg_addr == REG_CTRL);
    assign status_wr = accept && !hba_rnw && (reg_addr == REG_STATUS);
    assign clr       = ctrl_wr && hba_dbus[2];

    always_comb begin
        a_s1_d    = quad_enc_a;
        b_s1_d    = quad_enc_b;
        a_s2_d    = a_s1_q;
        b_s2_d    = b_s1_q;
        prev_a_d  = a_s2_q;
        prev_b_d  = b_s2_q;
        en_d      = ctrl_wr ? hba_dbus[0] : en_q;
        intr_en_d = ctrl_wr ? hba_dbus[1] : intr_en_q;
        irq_d     = intr_en_q && (|moved_q);
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch]    = cnt_q[ch];
            shadow_d[ch] = snap ? cnt_q[ch] : shadow_q[ch];
            // Snapshot clears MOVED but a step on the same edge re-sets it.
            moved_d[ch]  = (moved_q[ch] && !snap) || (en_q && (step_inc[ch] || step_dec[ch]));
            err_d[ch]    = (clr || status_wr) ? 1'b0 : (err_q[ch] || step_bad[ch]);
            if (clr) begin
                cnt_d[ch] = '0;
            end else if (en_q && step_inc[ch]) begin
                cnt_d[ch] = cnt_q[ch] + 16'd1;
            end else if (en_q && step_dec[ch]) begin
                cnt_d[ch] = cnt_q[ch] - 16'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            state_q   <= ST_IDLE;
            rdata_q   <= '0;
            en_q      <= 1'b0;
            intr_en_q <= 1'b0;
            a_s1_q    <= '0;
            a_s2_q    <= '0;
            b_s1_q    <= '0;
            b_s2_q    <= '0;
            prev_a_q  <= '0;
            prev_b_q  <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            err_q     <= '0;
            moved_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            en_q      <= en_d;
            intr_en_q <= intr_en_d;
            a_s1_q    <= a_s1_d;
            a_s2_q    <= a_s2_d;
            b_s1_q    <= b_s1_d;
            b_s2_q    <= b_s2_d;
            prev_a_q  <= prev_a_d;
            prev_b_q  <= prev_b_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            err_q     <= err_d;
            moved_q   <= moved_d;
            irq_q     <= irq_d;
        end
    end

    assign hba_xferack_slave = (state_q == ST_ACK);
    assign hba_dbus_slave    = (state_q == ST_ACK) ? rdata_q : '0;
    assign slave_interrupt   = irq_q;

endmodule

// File: tb/tb_hba_quad.sv
// Directed bench for hba_quad: a transaction-level model checked every cycle,
// plus literal register expectations along the stimulus.
module tb_hba_quad;

    logic        hba_clk    = 1'b0;
    logic        hba_reset  = 1'b1;
    logic        hba_rnw    = 1'b1;
    logic        hba_select = 1'b0;
    logic [11:0] hba_abus   = '0;
    logic [7:0]  hba_dbus   = '0;
    logic [7:0]  hba_dbus_slave;
    logic        hba_xferack_slave;
    logic        slave_interrupt;
    logic [1:0]  quad_enc_a = '0;
    logic [1:0]  quad_enc_b = '0;

    hba_quad dut (
        .hba_clk           (hba_clk),
        .hba_reset         (hba_reset),
        .hba_rnw           (hba_rnw),
        .hba_select        (hba_select),
        .hba_abus          (hba_abus),
        .hba_dbus          (hba_dbus),
        .hba_dbus_slave    (hba_dbus_slave),
        .hba_xferack_slave (hba_xferack_slave),
        .slave_interrupt   (slave_interrupt),
        .quad_enc_a        (quad_enc_a),
        .quad_enc_b        (quad_enc_b)
    );

    always #5 hba_clk = ~hba_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Pins are seen by the decoder two edges after they are sampled; positions are
    // plain integers kept modulo 2^16; the step is the phase difference modulo 4.
    logic [1:0] ha [4] = '{default: '0};
    logic [1:0] hb [4] = '{default: '0};
    int         pos  [2] = '{0, 0};
    int         shad [2] = '{0, 0};
    bit         mov  [2] = '{0, 0};
    bit         err  [2] = '{0, 0};
    bit         m_en = 0, m_ien = 0, m_irq = 0, m_ack = 0, m_armed = 1;
    logic [7:0] m_rdata = '0;

    int         dd  [2];
    bit         ill [2];
    bit         hit, accept, snap, cw, sw, clr;
    logic [7:0] rd_now;

    function automatic int phase(input logic a, input logic b);
        return int'({b, a ^ b});
    endfunction

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            int df;
            df = (phase(ha[1][ch], hb[1][ch]) - phase(ha[2][ch], hb[2][ch])) & 3;
            dd[ch]  = (df == 1) ? 1 : (df == 3) ? -1 : 0;
            ill[ch] = (df == 2);
        end
        hit    = hba_select && (hba_abus[11:8] == 4'd3);
        accept = !m_ack && m_armed && hit;
        snap   = accept &&  hba_rnw && (hba_abus[7:0] == 8'd1);
        cw     = accept && !hba_rnw && (hba_abus[7:0] == 8'd0);
        sw     = accept && !hba_rnw && (hba_abus[7:0] == 8'd5);
        clr    = cw && hba_dbus[2];
        case (hba_abus[7:0])
            8'd0:    rd_now = {6'b0, m_ien, m_en};
            8'd1:    rd_now = 8'(pos[0]);
            8'd2:    rd_now = 8'(shad[0] >> 8);
            8'd3:    rd_now = 8'(shad[1]);
            8'd4:    rd_now = 8'(shad[1] >> 8);
            8'd5:    rd_now = {4'b0, mov[1], mov[0], err[1], err[0]};
            default: rd_now = 8'h00;
        endcase
    end

    always @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            for (int i = 0; i < 4; i++) begin
                ha[i] <= '0;
                hb[i] <= '0;
            end
            for (int ch = 0; ch < 2; ch++) begin
                pos[ch]  <= 0;
                shad[ch] <= 0;
                mov[ch]  <= 0;
                err[ch]  <= 0;
            end
            m_en <= 0; m_ien <= 0; m_irq <= 0; m_ack <= 0; m_armed <= 1; m_rdata <= '0;
        end else begin
            ha[0] <= quad_enc_a;
            hb[0] <= quad_enc_b;
            for (int i = 1; i < 4; i++) begin
                ha[i] <= ha[i-1];
                hb[i] <= hb[i-1];
            end
            if (m_ack) begin
                m_ack <= 0;
            end else if (!m_armed) begin
                m_armed <= !hba_select;
            end else if (accept) begin
                m_ack   <= 1;
                m_armed <= 0;
                m_rdata <= hba_rnw ? rd_now : 8'h00;
            end
            if (cw) begin
                m_en  <= hba_dbus[0];
                m_ien <= hba_dbus[1];
            end
            m_irq <= m_ien && (mov[0] || mov[1]);
            for (int ch = 0; ch < 2; ch++) begin
                if (snap) shad[ch] <= pos[ch];
                mov[ch] <= (mov[ch] && !snap) || (m_en && dd[ch] != 0);
                err[ch] <= (clr || sw) ? 1'b0 : (err[ch] || ill[ch]);
                if (clr)       pos[ch] <= 0;
                else if (m_en) pos[ch] <= (pos[ch] + dd[ch]) & 32'hFFFF;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge hba_clk) begin
        check("cyc_ack",  16'(hba_xferack_slave), 16'(m_ack));
        check("cyc_dbus", 16'(hba_dbus_slave),    m_ack ? 16'(m_rdata) : 16'h0);
        check("cyc_irq",  16'(slave_interrupt),   16'(m_irq));
    end

    // ---------------- stimulus helpers (entered at a negedge) ----------------
    task automatic xfer(input bit rnw, input logic [7:0] ra, input logic [7:0] wd,
                        output logic [7:0] rd);
        bit got;
        got        = 0;
        rd         = 8'h00;
        hba_select = 1'b1;
        hba_rnw    = rnw;
        hba_abus   = {4'd3, ra};
        hba_dbus   = wd;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge hba_clk);
            if (hba_xferack_slave) begin
                got = 1;
                rd  = hba_dbus_slave;
            end
        end
        hba_select = 1'b0;
        check("ack_seen", 16'(got), 16'd1);
        repeat (2) @(negedge hba_clk);
    endtask

    task automatic rd_chk(input logic [7:0] ra, input logic [7:0] exp, input string name);
        logic [7:0] v;
        xfer(1'b1, ra, 8'h00, v);
        check(name, 16'(v), 16'(exp));
    endtask

    task automatic wr(input logic [7:0] ra, input logic [7:0] wd);
        logic [7:0] v;
        xfer(1'b0, ra, wd, v);
    endtask

    task automatic set_pins(input int ch, input bit a, input bit b, input int wait_n);
        quad_enc_a[ch] = a;
        quad_enc_b[ch] = b;
        repeat (wait_n) @(negedge hba_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] fwd_ab [4];
        logic [7:0] v;
        int         acks;
        fwd_ab = '{2'b10, 2'b11, 2'b01, 2'b00};

        repeat (2) @(negedge hba_clk);
        hba_reset = 1'b0;
        @(negedge hba_clk);
        check("rst_ack",  16'(hba_xferack_slave), 16'h0);
        check("rst_dbus", 16'(hba_dbus_slave),    16'h0);
        check("rst_irq",  16'(slave_interrupt),   16'h0);
        for (int r = 0; r < 6; r++) rd_chk(8'(r), 8'h00, "rst_reg");

        // Forward: 16 steps on the left wheel.
        wr(8'd0, 8'h01);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) set_pins(0, fwd_ab[j][1], fwd_ab[j][0], 4);
        rd_chk(8'd5, 8'h04, "moved_l_before");
        rd_chk(8'd1, 8'h10, "fwd_left_lo");
        rd_chk(8'd2, 8'h00, "fwd_left_hi");
        rd_chk(8'd5, 8'h00, "moved_l_after");

        // Reverse wrap on the right wheel, then two forward steps.
        set_pins(1, 1'b0, 1'b1, 4);
        rd_chk(8'd1, 8'h10, "wrap_left_lo");
        rd_chk(8'd3, 8'hFF, "wrap_right_lo");
        rd_chk(8'd4, 8'hFF, "wrap_right_hi");
        set_pins(1, 1'b0, 1'b0, 4);
        set_pins(1, 1'b1, 1'b0, 4);
        rd_chk(8'd1, 8'h10, "up_left_lo");
        rd_chk(8'd3, 8'h01, "up_right_lo");
        rd_chk(8'd4, 8'h00, "up_right_hi");

        // Illegal double change on the left wheel.
        set_pins(0, 1'b1, 1'b1, 4);
        rd_chk(8'd5, 8'h01, "err_l_set");
        rd_chk(8'd1, 8'h10, "err_count_held");
        wr(8'd5, 8'h00);
        rd_chk(8'd5, 8'h00, "err_l_cleared");

        // Interrupt latency: right 10 -> 11.
        wr(8'd0, 8'h03);
        quad_enc_b[1] = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge hba_clk);
            check("irq_latency", 16'(slave_interrupt), (i >= 4) ? 16'h1 : 16'h0);
        end
        repeat (2) @(negedge hba_clk);

        // Snapshot on the same edge as a left step (11 -> 01).
        quad_enc_a[0] = 1'b0;
        repeat (2) @(negedge hba_clk);
        xfer(1'b1, 8'd1, 8'h00, v);
        check("snap_live_lo", 16'(v), 16'h10);
        check("snap_irq_held", 16'(slave_interrupt), 16'h1);
        rd_chk(8'd2, 8'h00, "snap_shadow_hi");
        rd_chk(8'd5, 8'h04, "snap_moved_l");
        rd_chk(8'd1, 8'h11, "snap_next_lo");
        check("irq_dropped", 16'(slave_interrupt), 16'h0);
        rd_chk(8'd3, 8'h02, "snap_right_lo");

        // Reset in the middle of an ack with the interrupt high.
        set_pins(1, 1'b0, 1'b1, 6);
        check("irq_before_rst", 16'(slave_interrupt), 16'h1);
        hba_select = 1'b1;
        hba_rnw    = 1'b1;
        hba_abus   = {4'd3, 8'd0};
        @(posedge hba_clk);
        #2;
        check("ack_before_rst", 16'(hba_xferack_slave), 16'h1);
        hba_reset = 1'b1;
        #1;
        check("midrst_ack",  16'(hba_xferack_slave), 16'h0);
        check("midrst_dbus", 16'(hba_dbus_slave),    16'h0);
        check("midrst_irq",  16'(slave_interrupt),   16'h0);
        hba_select = 1'b0;
        repeat (2) @(negedge hba_clk);
        hba_reset = 1'b0;
        @(negedge hba_clk);
        for (int r = 0; r < 6; r++) rd_chk(8'(r), 8'h00, "post_rst_reg");

        // Held select on a CTRL write with CLR: one ack, counts zeroed.
        wr(8'd0, 8'h01);
        set_pins(0, 1'b0, 1'b0, 4);
        set_pins(1, 1'b0, 1'b0, 4);
        rd_chk(8'd1, 8'h01, "pre_clr_left");
        rd_chk(8'd3, 8'h01, "pre_clr_right");
        hba_select = 1'b1;
        hba_rnw    = 1'b0;
        hba_abus   = {4'd3, 8'd0};
        hba_dbus   = 8'h07;
        acks       = 0;
        repeat (5) begin
            @(negedge hba_clk);
            if (hba_xferack_slave) acks++;
        end
        hba_select = 1'b0;
        check("hold_acks", 16'(acks), 16'd1);
        repeat (2) @(negedge hba_clk);
        rd_chk(8'd0, 8'h03, "ctrl_after_clr");
        rd_chk(8'd1, 8'h00, "clr_left_lo");
        rd_chk(8'd2, 8'h00, "clr_left_hi");
        rd_chk(8'd3, 8'h00, "clr_right_lo");
        rd_chk(8'd4, 8'h00, "clr_right_hi");

        // Another slot must never be acknowledged.
        hba_select = 1'b1;
        hba_rnw    = 1'b1;
        hba_abus   = {4'd2, 8'd0};
        repeat (4) begin
            @(negedge hba_clk);
            check("slot2_ack",  16'(hba_xferack_slave), 16'h0);
            check("slot2_dbus", 16'(hba_dbus_slave),    16'h0);
        end
        hba_select = 1'b0;
        repeat (2) @(negedge hba_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
